// File: rtl/rojo_colorizer.sv
// rojo_colorizer: final pixel colour stage for the robot-world display.
// Delays the pixel timing/world-map signals to line up with the lagging robot
// icon stream, then selects blank / icon / palette colour in one registered stage.
// Optional build macro: ROJO_COLORIZER_PALETTE_WR_EN enables runtime palette writes;
// without it the palette is fixed at the COLOR_* parameters and pal_* are ignored.

module rojo_colorizer #(
  parameter int unsigned ICON_LATENCY = 1,
  parameter logic [11:0] COLOR_BG     = 12'hFFF,
  parameter logic [11:0] COLOR_LINE   = 12'h001,
  parameter logic [11:0] COLOR_OBST   = 12'hF00,
  parameter logic [11:0] COLOR_RSVD   = 12'h0F0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [1:0]  world_pixel,
  input  logic [11:0] icon,
  input  logic        pal_we,
  input  logic [1:0]  pal_addr,
  input  logic [11:0] pal_wdata,
  output logic [11:0] rgb_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  // Pixel-timing signals after the ICON_LATENCY alignment delay
  logic       dly_video;
  logic       dly_hsync;
  logic       dly_vsync;
  logic [1:0] dly_world;

  logic [11:0] palette [4];

  logic [11:0] rgb_d, rgb_q;
  logic        hsync_q, vsync_q;

  if (ICON_LATENCY == 0) begin : g_passthru
    assign dly_video = video_on;
    assign dly_hsync = hsync_in;
    assign dly_vsync = vsync_in;
    assign dly_world = world_pixel;
  end else begin : g_delay
    logic [ICON_LATENCY-1:0]      video_q;
    logic [ICON_LATENCY-1:0]      hsync_q_pipe;
    logic [ICON_LATENCY-1:0]      vsync_q_pipe;
    logic [ICON_LATENCY-1:0][1:0] world_q;

    // Shift pipeline; resets to a blanked, sync-idle pixel so no stale data leaks out
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        video_q      <= '0;
        hsync_q_pipe <= '1;
        vsync_q_pipe <= '1;
        world_q      <= '0;
      end else begin
        video_q[0]      <= video_on;
        hsync_q_pipe[0] <= hsync_in;
        vsync_q_pipe[0] <= vsync_in;
        world_q[0]      <= world_pixel;
        for (int unsigned i = 1; i < ICON_LATENCY; i++) begin
          video_q[i]      <= video_q[i-1];
          hsync_q_pipe[i] <= hsync_q_pipe[i-1];
          vsync_q_pipe[i] <= vsync_q_pipe[i-1];
          world_q[i]      <= world_q[i-1];
        end
      end
    end

    assign dly_video = video_q[ICON_LATENCY-1];
    assign dly_hsync = hsync_q_pipe[ICON_LATENCY-1];
    assign dly_vsync = vsync_q_pipe[ICON_LATENCY-1];
    assign dly_world = world_q[ICON_LATENCY-1];
  end

`ifdef ROJO_COLORIZER_PALETTE_WR_EN
  // Writable palette; a lookup in the write cycle still sees the old entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      palette[0] <= COLOR_BG;
      palette[1] <= COLOR_LINE;
      palette[2] <= COLOR_OBST;
      palette[3] <= COLOR_RSVD;
    end else if (pal_we) begin
      palette[pal_addr] <= pal_wdata;
    end
  end
`else
  logic unused_pal_inputs;
  assign unused_pal_inputs = ^{pal_we, pal_addr, pal_wdata};

  // Fixed palette
  always_comb begin
    palette[0] = COLOR_BG;
    palette[1] = COLOR_LINE;
    palette[2] = COLOR_OBST;
    palette[3] = COLOR_RSVD;
  end
`endif

  // Colour select: blank outside active video, opaque icon wins over the map
  always_comb begin
    rgb_d = 12'h000;
    if (dly_video) begin
      rgb_d = (icon != 12'h000) ? icon : palette[dly_world];
    end
  end

  // Output register; syncs ride alongside so they stay aligned with rgb_out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q   <= 12'h000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= dly_hsync;
      vsync_q <= dly_vsync;
    end
  end

  assign rgb_out   = rgb_q;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;

endmodule

// File: tb/tb_rojo_colorizer.sv
// Bench for rojo_colorizer: three instances (ICON_LATENCY 1, 0, 3) share stimulus and
// are checked against a per-cycle history model of the pixel stream.

module tb_rojo_colorizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        video_on, hsync_in, vsync_in;
  logic [1:0]  world_pixel;
  logic [11:0] icon;
  logic        pal_we;
  logic [1:0]  pal_addr;
  logic [11:0] pal_wdata;

  logic [11:0] rgb1, rgb0, rgb3;
  logic        hs1, vs1, hs0, vs0, hs3, vs3;

  always #5 clk = ~clk;

  rojo_colorizer #(.ICON_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .world_pixel(world_pixel), .icon(icon), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_wdata(pal_wdata), .rgb_out(rgb1), .hsync_out(hs1),
    .vsync_out(vs1)
  );

  rojo_colorizer #(.ICON_LATENCY(0)) dut_l0 (
    .clk(clk), .reset(reset), .video_on(video_on), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .world_pixel(world_pixel), .icon(icon), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_wdata(pal_wdata), .rgb_out(rgb0), .hsync_out(hs0),
    .vsync_out(vs0)
  );

  rojo_colorizer #(.ICON_LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset), .video_on(video_on), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .world_pixel(world_pixel), .icon(icon), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_wdata(pal_wdata), .rgb_out(rgb3), .hsync_out(hs3),
    .vsync_out(vs3)
  );

  int checks = 0;
  int errors = 0;

  // Model: h_*[k] is the input applied k edges before the most recent edge
  int          lat [3] = '{1, 0, 3};
  logic        h_vid [4];
  logic        h_hs  [4];
  logic        h_vs  [4];
  logic [1:0]  h_wp  [4];
  logic [11:0] m_pal [4];
  logic [13:0] exp_o [3];

  function automatic logic [13:0] obs(int i);
    case (i)
      0:       return {rgb1, hs1, vs1};
      1:       return {rgb0, hs0, vs0};
      default: return {rgb3, hs3, vs3};
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      h_vid[k] = 1'b0; h_hs[k] = 1'b1; h_vs[k] = 1'b1; h_wp[k] = 2'd0;
    end
    m_pal[0] = 12'hFFF; m_pal[1] = 12'h001; m_pal[2] = 12'hF00; m_pal[3] = 12'h0F0;
    for (int i = 0; i < 3; i++) exp_o[i] = {12'h000, 1'b1, 1'b1};
  endtask

  task automatic drive(input logic v, input logic h, input logic vs, input logic [1:0] wp,
                       input logic [11:0] ic);
    video_on = v; hsync_in = h; vsync_in = vs; world_pixel = wp; icon = ic;
  endtask

  // One rising edge; model output for latency L uses pixel data from L edges back
  // and the icon present at the edge itself. Returns 1ns after the edge.
  task automatic step();
    logic [11:0] rgb;
    @(posedge clk);
    for (int k = 3; k > 0; k--) begin
      h_vid[k] = h_vid[k-1]; h_hs[k] = h_hs[k-1]; h_vs[k] = h_vs[k-1]; h_wp[k] = h_wp[k-1];
    end
    h_vid[0] = video_on; h_hs[0] = hsync_in; h_vs[0] = vsync_in; h_wp[0] = world_pixel;
    for (int i = 0; i < 3; i++) begin
      if (!h_vid[lat[i]])      rgb = 12'h000;
      else if (icon != 12'h000) rgb = icon;
      else                      rgb = m_pal[h_wp[lat[i]]];
      exp_o[i] = {rgb, h_hs[lat[i]], h_vs[lat[i]]};
    end
`ifdef ROJO_COLORIZER_PALETTE_WR_EN
    if (pal_we) m_pal[pal_addr] = pal_wdata;
`endif
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs(i) !== {12'h000, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL reset_state lat=%0d got %h want %h", lat[i], obs(i), {12'h000, 2'b11});
      end
    end
  endtask

  task automatic test_palette_pixel();
    drive(1'b1, 1'b1, 1'b1, 2'd2, 12'h000);
    for (int s = 1; s <= 2; s++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== exp_o[i]) begin
          errors++;
          $display("FAIL palette_pixel lat=%0d s=%0d got %h want %h", lat[i], s, obs(i), exp_o[i]);
        end
      end
    end
    checks++;
    if (rgb1 !== 12'hF00) begin
      errors++;
      $display("FAIL obst_two_clocks got %h want %h", rgb1, 12'hF00);
    end
  endtask

  task automatic test_icon_priority();
    drive(1'b1, 1'b1, 1'b1, 2'd0, 12'h0AB);
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs(i) !== exp_o[i]) begin
        errors++;
        $display("FAIL icon_priority lat=%0d got %h want %h", lat[i], obs(i), exp_o[i]);
      end
    end
    checks++;
    if (rgb1 !== 12'h0AB || rgb0 !== 12'h0AB) begin
      errors++;
      $display("FAIL icon_one_clock got %h/%h want %h", rgb1, rgb0, 12'h0AB);
    end
  endtask

  task automatic test_blank_and_sync();
    drive(1'b0, 1'b0, 1'b1, 2'd1, 12'hFFF);  // hsync pulse on cycle N
    for (int s = 1; s <= 6; s++) begin
      step();
      hsync_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== exp_o[i]) begin
          errors++;
          $display("FAIL blank_sync lat=%0d s=%0d got %h want %h", lat[i], s, obs(i), exp_o[i]);
        end
      end
      checks++;
      if (hs0 !== (s != 1) || hs3 !== (s != 4)) begin
        errors++;
        $display("FAIL hsync_delay s=%0d got l0=%b l3=%b want l0=%b l3=%b",
                 s, hs0, hs3, (s != 1), (s != 4));
      end
    end
    checks++;
    if (rgb0 !== 12'h000 || rgb3 !== 12'h000) begin
      errors++;
      $display("FAIL blank_icon got %h/%h want %h", rgb0, rgb3, 12'h000);
    end
  endtask

  task automatic test_palette_write();
    logic [11:0] want_new;
`ifdef ROJO_COLORIZER_PALETTE_WR_EN
    want_new = 12'h00F;
`else
    want_new = 12'hFFF;
`endif
    drive(1'b1, 1'b1, 1'b1, 2'd0, 12'h000);
    for (int s = 0; s < 6; s++) begin
      if (s == 4) begin pal_we = 1'b1; pal_addr = 2'd0; pal_wdata = 12'h00F; end
      step();
      pal_we = 1'b0; pal_addr = 2'd0; pal_wdata = 12'h000;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== exp_o[i]) begin
          errors++;
          $display("FAIL pal_write lat=%0d s=%0d got %h want %h", lat[i], s, obs(i), exp_o[i]);
        end
      end
      checks++;
      if (s == 4 && rgb0 !== 12'hFFF) begin
        errors++;
        $display("FAIL pal_write_old got %h want %h", rgb0, 12'hFFF);
      end else if (s == 5 && rgb0 !== want_new) begin
        errors++;
        $display("FAIL pal_write_new got %h want %h", rgb0, want_new);
      end
    end
  endtask

  task automatic test_reset_midline();
    drive(1'b1, 1'b1, 1'b1, 2'd2, 12'h000);
    repeat (4) step();
    checks++;
    if (rgb1 !== 12'hF00) begin
      errors++;
      $display("FAIL midline_pre got %h want %h", rgb1, 12'hF00);
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs(i) !== {12'h000, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL midline_async lat=%0d got %h want %h", lat[i], obs(i), {12'h000, 2'b11});
      end
    end
    #3 reset = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 2'd0, 12'h000);
    for (int s = 1; s <= 5; s++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== exp_o[i]) begin
          errors++;
          $display("FAIL post_reset lat=%0d s=%0d got %h want %h", lat[i], s, obs(i), exp_o[i]);
        end
      end
      checks++;
      if (rgb1 !== ((s == 1) ? 12'h000 : 12'hFFF)) begin
        errors++;
        $display("FAIL post_reset_default s=%0d got %h want %h", s, rgb1,
                 (s == 1) ? 12'h000 : 12'hFFF);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 4) != 0, ($urandom % 8) != 0, ($urandom % 16) != 0,
            2'($urandom % 4), (($urandom % 2) == 0) ? 12'h000 : 12'($urandom));
      pal_we    = ($urandom % 8) == 0;
      pal_addr  = 2'($urandom % 4);
      pal_wdata = 12'($urandom);
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== exp_o[i]) begin
          errors++;
          $display("FAIL random lat=%0d n=%0d got %h want %h", lat[i], n, obs(i), exp_o[i]);
        end
      end
    end
    pal_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 2'd0, 12'h000);
    pal_we = 1'b0; pal_addr = 2'd0; pal_wdata = 12'h000;
    model_reset();
    #2;
    test_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    test_palette_pixel();
    test_icon_priority();
    test_blank_and_sync();
    test_palette_write();
    test_reset_midline();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
